spi_adc_sampler: RTL

Audio front-end stage directly downstream of the clock divider. It consumes the divided clock as a rate strobe and runs an SPI read of a 12-bit serial microphone ADC (MCP3201-style: CS-framed, null/lead bits, then MSB-first data). Each completed frame produces one sample word with a one-cycle valid pulse for the visualizer's level/FFT stages. The block uses only the system clock; the divided clock never clocks any register.

---
 rtl/spi_adc_sampler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/spi_adc_sampler.sv
// spi_adc_sampler: reads a CS-framed, MSB-first serial ADC (MCP3201 style)
// once per frame, paced by rising edges of a same-domain divided clock.
// The divided clock is only sampled as data; every register runs on inClock.
//
// Output handshake: sample_valid is a one-cycle strobe with no backpressure.
// sample changes only in the cycle sample_valid is high and then holds until
// the next strobe; a consumer that misses a strobe simply loses that word.
module spi_adc_sampler #(
  parameter int DATA_BITS  = 12,
  parameter int LEAD_BITS  = 3,
  parameter int IDLE_TICKS = 2
) (
  input  logic                 inClock,
  input  logic                 rst,
  input  logic                 div_clk,
  input  logic                 enable,
  input  logic                 adc_miso,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy
);

  localparam int FRAME_BITS = LEAD_BITS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int IDLE_W     = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS) : 1;
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_BITS);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic                 div_q;
  logic                 tick;
  logic [IDLE_W-1:0]    idle_cnt, idle_cnt_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] sample_nxt;
  logic                 cs_n_nxt, sclk_nxt, valid_nxt;

  // One-cycle strobe on each rising edge of the divided clock.
  assign tick = div_clk & ~div_q;
  assign busy = (state != IDLE);

  // State and datapath registers; reset parks the bus idle and clears data.
  always_ff @(posedge inClock) begin
    if (rst) begin
      state        <= IDLE;
      div_q        <= 1'b0;
      idle_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      div_q        <= div_clk;
      idle_cnt     <= idle_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift        <= shift_nxt;
      adc_cs_n     <= cs_n_nxt;
      adc_sclk     <= sclk_nxt;
      sample       <= sample_nxt;
      sample_valid <= valid_nxt;
    end
  end

  // Next-state and output decode; everything holds except on tick cycles,
  // and the valid strobe drops on any cycle it is not explicitly raised.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    cs_n_nxt     = adc_cs_n;
    sclk_nxt     = adc_sclk;
    sample_nxt   = sample;
    valid_nxt    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (enable) begin
            if (idle_cnt == IDLE_LAST) begin
              cs_n_nxt     = 1'b0;
              idle_cnt_nxt = '0;
              state_nxt    = SETUP;
            end else begin
              idle_cnt_nxt = idle_cnt + 1'b1;
            end
          end
        end
        SETUP: begin
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
        SHIFT: begin
          if (!adc_sclk) begin
            // Capture on the rising SCLK edge; lead bits fall off the top.
            sclk_nxt    = 1'b1;
            shift_nxt   = DATA_BITS'({shift, adc_miso});
            bit_cnt_nxt = bit_cnt + 1'b1;
          end else begin
            sclk_nxt = 1'b0;
            if (bit_cnt == FRAME_LAST) begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          cs_n_nxt     = 1'b1;
          sample_nxt   = shift;
          valid_nxt    = 1'b1;
          idle_cnt_nxt = '0;
          state_nxt    = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
